rvsteel_uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one rvsteel_uart transmitter between NUM_REQUESTERS byte-stream sources.
- Acts as the bus master on the UART IO interface:
  - polls the READY register (0x08);
  - writes the granted byte to WDATA (0x00) once the transmitter is idle.
- Optional message locking keeps a requester's multi-byte message contiguous, with a timeout for stalled senders.

---
 rtl/rvsteel_uart_tx_arbiter.sv | 148 ++++++++++++++
 tb/tb_rvsteel_uart_tx_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvsteel_uart_tx_arbiter.sv
// Round-robin arbiter sharing one rvsteel_uart transmitter between several byte sources.
// Polls READY (0x08) and writes the granted byte to WDATA (0x00), optionally keeping messages contiguous.
module rvsteel_uart_tx_arbiter #(
  parameter int NUM_REQUESTERS = 2,
  parameter int LOCK_ENABLE    = 1,
  parameter int LOCK_TIMEOUT   = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQUESTERS-1:0]     src_valid,
  input  logic [8*NUM_REQUESTERS-1:0]   src_data,
  input  logic [NUM_REQUESTERS-1:0]     src_last,
  output logic [NUM_REQUESTERS-1:0]     src_ready,
  output logic [4:0]                    uart_rw_address,
  output logic                          uart_read_request,
  input  logic [31:0]                   uart_read_data,
  input  logic                          uart_read_response,
  output logic [7:0]                    uart_write_data,
  output logic                          uart_write_request,
  input  logic                          uart_write_response,
  output logic                          busy,
  output logic [1:0]                    grant_id
);

  localparam int         TW       = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [1:0] LAST_IDX = 2'(NUM_REQUESTERS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_POLL, S_POLL_WAIT, S_WRITE, S_WRITE_WAIT, S_HOLD
  } state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_rr_ptr, r_grant, w_winner, w_sel;
  logic [TW-1:0]   r_timer;
  logic [4:0]      r_addr;
  logic            r_rd_req, r_wr_req;
  logic [7:0]      r_wdata, r_byte, w_byte;
  logic            r_last, w_last;
  logic            w_any, w_hold_valid, w_accept, w_timeout, w_release;
  int              w_pos;
  logic            w_unused;

  assign w_unused = ^uart_read_data[31:1];

  // Downward scan so the source closest to r_rr_ptr is the last (winning) assignment.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_pos    = 0;
    for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
      w_pos = (int'(r_rr_ptr) + k) % NUM_REQUESTERS;
      for (int j = 0; j < NUM_REQUESTERS; j++) begin
        if (j == w_pos && src_valid[j]) begin
          w_any    = 1'b1;
          w_winner = 2'(j);
        end
      end
    end
  end

  assign w_sel = (r_state == S_HOLD) ? r_grant : w_winner;

  always_comb begin
    w_hold_valid = 1'b0;
    w_byte       = '0;
    w_last       = 1'b0;
    for (int j = 0; j < NUM_REQUESTERS; j++) begin
      if (2'(j) == r_grant) w_hold_valid = src_valid[j];
      if (2'(j) == w_sel) begin
        w_byte = src_data[8*j +: 8];
        w_last = src_last[j];
      end
    end
  end

  assign w_accept = !reset && (((r_state == S_IDLE) && w_any) ||
                               ((r_state == S_HOLD) && w_hold_valid));

  always_comb begin
    src_ready = '0;
    for (int j = 0; j < NUM_REQUESTERS; j++) begin
      if (w_accept && (2'(j) == w_sel)) src_ready[j] = 1'b1;
    end
  end

  // Timer counts idle HOLD cycles; release happens as it reaches LOCK_TIMEOUT-1.
  assign w_timeout = (LOCK_TIMEOUT != 0) && ((int'(r_timer) + 1) >= (LOCK_TIMEOUT - 1));

  assign w_release = ((r_state == S_WRITE_WAIT) && uart_write_response &&
                      ((LOCK_ENABLE == 0) || r_last)) ||
                     ((r_state == S_HOLD) && !w_hold_valid && w_timeout);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (w_any) w_next = S_POLL;
      S_POLL:       w_next = S_POLL_WAIT;
      S_POLL_WAIT:  if (uart_read_response) w_next = uart_read_data[0] ? S_WRITE : S_POLL;
      S_WRITE:      w_next = S_WRITE_WAIT;
      S_WRITE_WAIT: if (uart_write_response)
                      w_next = ((LOCK_ENABLE == 0) || r_last) ? S_IDLE : S_HOLD;
      S_HOLD:       if (w_hold_valid) w_next = S_POLL;
                    else if (w_timeout) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // Control and registered bus outputs; strobes are decoded from the next state.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_addr   <= '0;
      r_rd_req <= 1'b0;
      r_wr_req <= 1'b0;
      r_wdata  <= '0;
      r_timer  <= '0;
    end else begin
      r_state  <= w_next;
      r_rd_req <= (w_next == S_POLL);
      r_wr_req <= (w_next == S_WRITE);
      if (w_next == S_POLL)       r_addr <= 5'h08;
      else if (w_next == S_WRITE) r_addr <= 5'h00;
      if (w_next == S_WRITE) r_wdata <= r_byte;
      if (w_accept) r_grant <= w_sel;
      if (w_release) r_rr_ptr <= (r_grant == LAST_IDX) ? 2'd0 : 2'(r_grant + 2'd1);
      if ((r_state == S_HOLD) && !w_hold_valid) r_timer <= r_timer + TW'(1);
      else                                      r_timer <= '0;
    end
  end

  // Captured byte; w_accept is already masked by reset.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_byte <= w_byte;
      r_last <= w_last;
    end
  end

  assign uart_rw_address    = r_addr;
  assign uart_read_request  = r_rd_req && !reset;
  assign uart_write_request = r_wr_req && !reset;
  assign uart_write_data    = r_wdata;
  assign grant_id           = r_grant;
  assign busy               = (r_state != S_IDLE);

endmodule

// File: tb/tb_rvsteel_uart_tx_arbiter.sv
// Scoreboard bench for rvsteel_uart_tx_arbiter: message-level round-robin model, UART responder,
// source drivers and a write monitor that pops expected bytes.
module tb_rvsteel_uart_tx_arbiter;
  localparam int NREQ = 3;
  localparam int LOCK = 1;
  localparam int TMO  = 8;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     src_valid;
  logic [8*NREQ-1:0]   src_data;
  logic [NREQ-1:0]     src_last;
  logic [NREQ-1:0]     src_ready;
  logic [4:0]          uart_rw_address;
  logic                uart_read_request;
  logic [31:0]         uart_read_data;
  logic                uart_read_response;
  logic [7:0]          uart_write_data;
  logic                uart_write_request;
  logic                uart_write_response;
  logic                busy;
  logic [1:0]          grant_id;

  rvsteel_uart_tx_arbiter #(
    .NUM_REQUESTERS(NREQ), .LOCK_ENABLE(LOCK), .LOCK_TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .src_valid(src_valid), .src_data(src_data), .src_last(src_last), .src_ready(src_ready),
    .uart_rw_address(uart_rw_address), .uart_read_request(uart_read_request),
    .uart_read_data(uart_read_data), .uart_read_response(uart_read_response),
    .uart_write_data(uart_write_data), .uart_write_request(uart_write_request),
    .uart_write_response(uart_write_response), .busy(busy), .grant_id(grant_id)
  );

  int          total = 0, bad = 0, cyc = 0, reads = 0, writes = 0, last_wr_cyc = 0;
  int          ready_cnt [NREQ];
  int          ready_cyc [NREQ];
  logic [8:0]  srcq [NREQ][$];
  logic [8:0]  mq   [NREQ][$];
  int          mptr = 0;
  logic [9:0]  exp_q[$];
  int          wr_resp_cycs[$];
  bit          ready_pat[$];
  int          maxd = 0, ready_prob = 100;
  bit          mute = 1'b0, ready_seen = 1'b0;
  bit          prev_rd = 1'b0, prev_wr = 1'b0;
  logic [9:0]  e;

  initial forever #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Source drivers: present queue heads, pop on src_ready.
  initial begin
    logic [8:0] h;
    for (int i = 0; i < NREQ; i++) begin ready_cnt[i] = 0; ready_cyc[i] = 0; end
    src_valid = '0; src_data = '0; src_last = '0;
    forever begin
      @(negedge clock);
      if (src_ready != '0) begin
        chk("ready_onehot", $countones(src_ready), 1);
        for (int i = 0; i < NREQ; i++) begin
          if (src_ready[i]) begin
            chk("ready_has_valid", srcq[i].size() > 0, 1);
            if (srcq[i].size() > 0) void'(srcq[i].pop_front());
            ready_cnt[i]++;
            ready_cyc[i] = cyc;
          end
        end
      end
      @(posedge clock); #1;
      for (int i = 0; i < NREQ; i++) begin
        src_valid[i] = (srcq[i].size() != 0);
        h = (srcq[i].size() != 0) ? srcq[i][0] : 9'h0;
        src_data[8*i +: 8] = h[7:0];
        src_last[i] = h[8];
      end
    end
  end

  // UART responder with configurable latency and READY pattern.
  initial begin
    int rd_cnt, wr_cnt;
    bit rb;
    rd_cnt = -1; wr_cnt = -1;
    uart_read_response = 1'b0; uart_write_response = 1'b0; uart_read_data = '0;
    forever begin
      @(negedge clock);
      if (uart_read_request && !mute) rd_cnt = int'($urandom_range(0, maxd));
      if (uart_write_request) wr_cnt = int'($urandom_range(0, maxd));
      @(posedge clock); #1;
      uart_read_response = 1'b0; uart_write_response = 1'b0; uart_read_data = $urandom();
      if (rd_cnt == 0) begin
        if (ready_pat.size() > 0) rb = ready_pat.pop_front();
        else rb = ($urandom_range(0, 99) < ready_prob);
        uart_read_response = 1'b1;
        uart_read_data[0] = rb;
        if (rb) ready_seen = 1'b1;
      end
      if (wr_cnt == 0) begin
        uart_write_response = 1'b1;
        wr_resp_cycs.push_back(cyc);
      end
      if (rd_cnt >= 0) rd_cnt--;
      if (wr_cnt >= 0) wr_cnt--;
    end
  end

  // Monitor: bus protocol checks and scoreboard pop on every write.
  initial begin
    forever begin
      @(negedge clock);
      if (uart_read_request) begin
        reads++;
        chk("rd_addr", uart_rw_address, 8);
        chk("rd_wr_exclusive", uart_write_request, 0);
        chk("rd_single_cycle", prev_rd, 0);
      end
      if (uart_write_request) begin
        writes++;
        last_wr_cyc = cyc;
        chk("wr_addr", uart_rw_address, 0);
        chk("wr_after_ready", ready_seen, 1);
        chk("wr_single_cycle", prev_wr, 0);
        ready_seen = 1'b0;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_write: actual=%0h required=none", uart_write_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_data", uart_write_data, e[7:0]);
          chk("wr_grant", grant_id, e[9:8]);
        end
      end
      prev_rd = uart_read_request;
      prev_wr = uart_write_request;
    end
  end

  task automatic load(input int src, input logic [8:0] b);
    srcq[src].push_back(b);
    mq[src].push_back(b);
  endtask

  function automatic bit model_pending();
    bit p = 1'b0;
    for (int i = 0; i < NREQ; i++) if (mq[i].size() > 0) p = 1'b1;
    return p;
  endfunction

  // Message-level round robin: winner sends its whole message (or one byte unlocked).
  task automatic model_run();
    int w;
    logic [8:0] b;
    bit more;
    while (model_pending()) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && mq[(mptr + k) % NREQ].size() > 0) w = (mptr + k) % NREQ;
      more = 1'b1;
      while (more) begin
        b = mq[w].pop_front();
        exp_q.push_back({2'(w), b[7:0]});
        more = (LOCK != 0) && !b[8] && (mq[w].size() > 0);
      end
      mptr = (w + 1) % NREQ;
    end
  endtask

  function automatic bit srcs_empty();
    bit em = 1'b1;
    for (int i = 0; i < NREQ; i++) if (srcq[i].size() > 0) em = 1'b0;
    return em;
  endfunction

  task automatic wait_idle(input string name, input int limit);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < limit) begin
      @(negedge clock);
      n++;
      done = (exp_q.size() == 0) && !busy && srcs_empty();
    end
    chk(name, done, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    mptr = 0;
  endtask

  initial begin
    int r0, w0, c0, c1, n, nm, len;
    // Reset state, with source 0 already presenting 0x41.
    load(0, {1'b1, 8'h41});
    model_run();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_rd", uart_read_request, 0);
    chk("rst_wr", uart_write_request, 0);
    chk("rst_addr", uart_rw_address, 0);
    chk("rst_wdata", uart_write_data, 0);
    chk("rst_src_ready", src_ready, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    wait_idle("single_drain", 200);
    chk("single_reads", reads, 1);
    chk("single_writes", writes, 1);
    chk("single_ready0", ready_cnt[0], 1);
    chk("single_latency", last_wr_cyc - ready_cyc[0], 3);

    // Transmitter busy three times before READY.
    r0 = reads; w0 = writes;
    ready_pat.push_back(1'b0); ready_pat.push_back(1'b0);
    ready_pat.push_back(1'b0); ready_pat.push_back(1'b1);
    load(2, {1'b1, 8'h5A});
    model_run();
    wait_idle("busy_drain", 300);
    chk("busy_reads", reads - r0, 4);
    chk("busy_writes", writes - w0, 1);

    // Fairness between two continuously valid sources.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      load(0, {1'b1, 8'hA0});
      load(1, {1'b1, 8'hB1});
    end
    model_run();
    wait_idle("fair_drain", 500);

    // Message lock: source 1 message stays contiguous while source 0 waits.
    do_reset();
    c0 = ready_cnt[0]; c1 = ready_cnt[1];
    srcq[1].push_back({1'b0, 8'h10});
    srcq[1].push_back({1'b0, 8'h11});
    srcq[1].push_back({1'b1, 8'h12});
    exp_q.push_back({2'd1, 8'h10}); exp_q.push_back({2'd1, 8'h11});
    exp_q.push_back({2'd1, 8'h12}); exp_q.push_back({2'd0, 8'h55});
    n = 0;
    while (ready_cnt[1] == c1 && n < 50) begin @(negedge clock); n++; end
    chk("lock_first_grant", ready_cnt[1] > c1, 1);
    srcq[0].push_back({1'b1, 8'h55});
    wait_idle("lock_drain", 500);
    chk("lock_src0_once", ready_cnt[0] - c0, 1);

    // Lock timeout: source 0 stalls mid-message, source 1 takes over after TMO cycles.
    do_reset();
    wr_resp_cycs.delete();
    c0 = ready_cnt[0];
    srcq[0].push_back({1'b0, 8'h01});
    srcq[1].push_back({1'b1, 8'h22});
    exp_q.push_back({2'd0, 8'h01}); exp_q.push_back({2'd1, 8'h22});
    wait_idle("tmo_drain", 300);
    chk("tmo_resp_count", wr_resp_cycs.size(), 2);
    if (wr_resp_cycs.size() > 0) chk("tmo_gap", ready_cyc[1] - wr_resp_cycs[0], TMO);
    chk("tmo_src0_once", ready_cnt[0] - c0, 1);

    // Reset during POLL_WAIT: byte dropped, pointer and grant cleared.
    do_reset();
    srcq[0].push_back({1'b1, 8'h3C});
    exp_q.push_back({2'd0, 8'h3C});
    wait_idle("mid_pre_drain", 200);
    mute = 1'b1;
    r0 = reads; w0 = writes;
    srcq[2].push_back({1'b1, 8'h77});
    n = 0;
    while (reads == r0 && n < 50) begin @(negedge clock); n++; end
    chk("mid_poll_seen", reads > r0, 1);
    @(posedge clock); #1;
    reset = 1'b1;
    @(negedge clock);
    chk("mid_rst_rd", uart_read_request, 0);
    chk("mid_rst_wr", uart_write_request, 0);
    chk("mid_rst_ready", src_ready, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    mptr = 0;
    @(negedge clock);
    chk("mid_busy", busy, 0);
    chk("mid_grant", grant_id, 0);
    chk("mid_rd", uart_read_request, 0);
    chk("mid_wr", uart_write_request, 0);
    mute = 1'b0;
    repeat (30) @(negedge clock);
    chk("mid_no_write", writes - w0, 0);
    load(1, {1'b1, 8'h31});
    load(0, {1'b1, 8'h30});
    model_run();
    wait_idle("mid_post_drain", 200);

    // Randomized messages, latencies and READY responses.
    do_reset();
    maxd = 3; ready_prob = 60;
    for (int r = 0; r < 8; r++) begin
      for (int s = 0; s < NREQ; s++) begin
        nm = int'($urandom_range(0, 2));
        for (int m = 0; m < nm; m++) begin
          len = int'($urandom_range(1, 3));
          for (int b = 0; b < len; b++) load(s, {b == len - 1, 8'($urandom())});
        end
      end
      model_run();
      wait_idle("rand_drain", 3000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
